// File: rtl/rename_pipe_ctrl_pkg.sv
// Shared types and defaults for the decode/rename pipeline controller.
package ctrl_pkg;

    typedef enum logic [1:0] {
        RC_INIT    = 2'd0,
        RC_RUN     = 2'd1,
        RC_FLUSH   = 2'd2,
        RC_RECOVER = 2'd3
    } rename_ctrl_state_t;

    localparam int RC_INIT_CYCLES    = 4;
    localparam int RC_RECOVER_CYCLES = 3;

    // Larger of two integers, used to size the shared phase down-counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rename_pipe_ctrl_sat_counter.sv
// Saturating up-counter: counts strobes and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Count on inc, hold once every bit is set; synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/rename_pipe_ctrl.sv
// Pipeline controller for the decode -> decode/rename register -> rename path.
// Sequences free-list init after reset, steady-state back-pressure, and
// multi-cycle squash recovery; keeps saturating stall/recovery counters.
//
// Pause semantics: pipe_pause=1 in a cycle means the decode/rename register
// holds its contents and fetch must not advance in that same cycle; there is
// no ready/valid latency, so a stall and its release both act immediately.
module rename_pipe_ctrl
    import ctrl_pkg::*;
#(
    parameter int INIT_CYCLES    = RC_INIT_CYCLES,
    parameter int RECOVER_CYCLES = RC_RECOVER_CYCLES,
    parameter int PERF_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rename_allocatable,
    input  logic               dispatch_ready,
    input  logic               recover_req,
    output logic               pipe_pause,
    output logic               pipe_flush,
    output logic               rename_recover,
    output logic               fetch_pause_req,
    output logic               busy,
    output logic [PERF_W-1:0]  stall_cycles,
    output logic [PERF_W-1:0]  recover_count,
    output rename_ctrl_state_t state
);

    localparam int CNT_MAX = max_int(INIT_CYCLES, RECOVER_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD  = CNT_W'(RECOVER_CYCLES - 1);

    rename_ctrl_state_t state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               backpressure;
    logic               stall_inc;
    logic               recover_inc;

    // State and phase counter register; reset re-enters INIT from any state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RC_INIT;
            cnt_q   <= INIT_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a fresh squash in RECOVER restarts the flush sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RC_INIT: begin
                // Pipe is empty during init, so squash requests are ignored.
                if (cnt_q == '0) state_d = RC_RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RC_RUN: begin
                if (recover_req) state_d = RC_FLUSH;
            end
            RC_FLUSH: begin
                state_d = RC_RECOVER;
                cnt_d   = REC_LOAD;
            end
            RC_RECOVER: begin
                if (recover_req)       state_d = RC_FLUSH;
                else if (cnt_q == '0)  state_d = RC_RUN;
                else                   cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = RC_INIT;
                cnt_d   = INIT_LOAD;
            end
        endcase
    end

    assign backpressure    = !rename_allocatable || !dispatch_ready;
    assign pipe_pause      = (state_q != RC_RUN) || backpressure;
    assign fetch_pause_req = pipe_pause;
    assign pipe_flush      = (state_q == RC_FLUSH);
    assign rename_recover  = (state_q == RC_FLUSH);
    assign busy            = (state_q != RC_RUN);
    assign state           = state_q;

    assign stall_inc   = (state_q == RC_RUN) && pipe_pause;
    assign recover_inc = (state_d == RC_FLUSH);

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .value (stall_cycles)
    );

    sat_counter #(.W(PERF_W)) u_recover_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (recover_inc),
        .value (recover_count)
    );

endmodule

// File: tb/tb_rename_pipe_ctrl.sv
// Bench for rename_pipe_ctrl: INIT_CYCLES=4, RECOVER_CYCLES=3, PERF_W=4.
// Each driven cycle queues its hand-computed expected outputs; a negedge
// monitor pops and compares them.
module tb_rename_pipe_ctrl;
    import ctrl_pkg::*;

    localparam int PW = 4;

    typedef struct packed {
        rename_ctrl_state_t st;
        logic               p;
        logic               f;
        logic               b;
        logic [PW-1:0]      s;
        logic [PW-1:0]      rc;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rename_allocatable = 1'b1;
    logic dispatch_ready = 1'b1;
    logic recover_req = 1'b0;
    logic pipe_pause, pipe_flush, rename_recover, fetch_pause_req, busy;
    logic [PW-1:0] stall_cycles, recover_count;
    rename_ctrl_state_t state;

    logic [EXP_W-1:0] exp_q[$];
    exp_t mon_e;
    int checks_total  = 0;
    int checks_passed = 0;

    rename_pipe_ctrl #(
        .INIT_CYCLES    (4),
        .RECOVER_CYCLES (3),
        .PERF_W         (PW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rename_allocatable (rename_allocatable),
        .dispatch_ready     (dispatch_ready),
        .recover_req        (recover_req),
        .pipe_pause         (pipe_pause),
        .pipe_flush         (pipe_flush),
        .rename_recover     (rename_recover),
        .fetch_pause_req    (fetch_pause_req),
        .busy               (busy),
        .stall_cycles       (stall_cycles),
        .recover_count      (recover_count),
        .state              (state)
    );

    // Clock and global time guard.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached (act=running exp=finished)");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s @%0t: act=%0d exp=%0d", name, $time, act, exp);
    endtask

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic step(input logic r, input logic a, input logic d, input logic q,
                        input rename_ctrl_state_t st, input logic p, input logic f,
                        input int s, input int rc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        rename_allocatable = a;
        dispatch_ready = d;
        recover_req = q;
        e.st = st;
        e.p  = p;
        e.f  = f;
        e.b  = (st != RC_RUN);
        e.s  = PW'(s);
        e.rc = PW'(rc);
        exp_q.push_back(EXP_W'(e));
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_t'(exp_q.pop_front());
            chk("state", int'(state), int'(mon_e.st));
            chk("pipe_pause", int'(pipe_pause), int'(mon_e.p));
            chk("fetch_pause_req", int'(fetch_pause_req), int'(mon_e.p));
            chk("pipe_flush", int'(pipe_flush), int'(mon_e.f));
            chk("rename_recover", int'(rename_recover), int'(mon_e.f));
            chk("busy", int'(busy), int'(mon_e.b));
            chk("stall_cycles", int'(stall_cycles), int'(mon_e.s));
            chk("recover_count", int'(recover_count), int'(mon_e.rc));
        end
    end

    // Directed stimulus.
    initial begin
        //    rst a  d  q   state       p  f  stall rc
        // Reset, then four INIT cycles with a squash request that must be ignored.
        step(0, 1, 1, 0, RC_INIT,    1, 0, 0, 0);
        step(1, 1, 1, 0, RC_INIT,    1, 0, 0, 0);
        step(1, 1, 1, 1, RC_INIT,    1, 0, 0, 0);
        step(1, 1, 1, 1, RC_INIT,    1, 0, 0, 0);
        step(1, 1, 1, 0, RC_INIT,    1, 0, 0, 0);
        step(1, 1, 1, 0, RC_RUN,     0, 0, 0, 0);
        // Back-pressure: allocatable low for 5 cycles, dispatch_ready low for 2.
        step(1, 0, 1, 0, RC_RUN,     1, 0, 0, 0);
        step(1, 0, 1, 0, RC_RUN,     1, 0, 1, 0);
        step(1, 0, 1, 0, RC_RUN,     1, 0, 2, 0);
        step(1, 0, 1, 0, RC_RUN,     1, 0, 3, 0);
        step(1, 0, 1, 0, RC_RUN,     1, 0, 4, 0);
        step(1, 1, 0, 0, RC_RUN,     1, 0, 5, 0);
        step(1, 1, 0, 0, RC_RUN,     1, 0, 6, 0);
        step(1, 1, 1, 0, RC_RUN,     0, 0, 7, 0);
        // Single one-cycle squash.
        step(1, 1, 1, 1, RC_RUN,     0, 0, 7, 0);
        step(1, 1, 1, 0, RC_FLUSH,   1, 1, 7, 1);
        step(1, 1, 1, 0, RC_RECOVER, 1, 0, 7, 1);
        step(1, 1, 1, 0, RC_RECOVER, 1, 0, 7, 1);
        step(1, 1, 1, 0, RC_RECOVER, 1, 0, 7, 1);
        step(1, 1, 1, 0, RC_RUN,     0, 0, 7, 1);
        // Squash coinciding with a stall, then a re-squash in the second RECOVER cycle.
        step(1, 0, 1, 1, RC_RUN,     1, 0, 7, 1);
        step(1, 1, 1, 0, RC_FLUSH,   1, 1, 8, 2);
        step(1, 1, 1, 0, RC_RECOVER, 1, 0, 8, 2);
        step(1, 1, 1, 1, RC_RECOVER, 1, 0, 8, 2);
        step(1, 1, 1, 0, RC_FLUSH,   1, 1, 8, 3);
        step(1, 1, 1, 0, RC_RECOVER, 1, 0, 8, 3);
        step(1, 1, 1, 0, RC_RECOVER, 1, 0, 8, 3);
        step(1, 1, 1, 0, RC_RECOVER, 1, 0, 8, 3);
        step(1, 1, 1, 0, RC_RUN,     0, 0, 8, 3);
        // Held squash request alternates FLUSH/RECOVER, then reset lands in RECOVER.
        step(1, 1, 1, 1, RC_RUN,     0, 0, 8, 3);
        step(1, 1, 1, 1, RC_FLUSH,   1, 1, 8, 4);
        step(1, 1, 1, 1, RC_RECOVER, 1, 0, 8, 4);
        step(1, 1, 1, 1, RC_FLUSH,   1, 1, 8, 5);
        step(1, 1, 1, 0, RC_RECOVER, 1, 0, 8, 5);
        step(1, 1, 1, 0, RC_RECOVER, 1, 0, 8, 5);
        step(0, 1, 1, 0, RC_RECOVER, 1, 0, 8, 5);
        step(1, 1, 1, 0, RC_INIT,    1, 0, 0, 0);
        step(1, 1, 1, 0, RC_INIT,    1, 0, 0, 0);
        step(1, 1, 1, 0, RC_INIT,    1, 0, 0, 0);
        step(1, 1, 1, 0, RC_INIT,    1, 0, 0, 0);
        // Saturation: 20 stalled RUN cycles, counter sticks at 15.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, RC_RUN, 1, 0, (i > 15) ? 15 : i, 0);
        end
        step(1, 1, 1, 0, RC_RUN,     0, 0, 15, 0);
        step(1, 1, 1, 0, RC_RUN,     0, 0, 15, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        checks_total++;
        if (exp_q.size() == 0) checks_passed++;
        else $display("FAIL drain: pending=%0d exp=0", exp_q.size());

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
